idelay_cal_ctrl: RTL and testbench
==================================

// Module: idelay_cal_ctrl
// PURPOSE
// Automatic tap calibration for the IDELAYE3 + IDDR input capture path. Sweeps the
// delay count over all taps while the far end sends a fixed training pattern, records
// the longest contiguous run of error-free taps, and loads its centre. Replaces the
// hand-swept fixed delay. Sits beside iddr; drives the CNTVALUEIN/LOAD/EN_VTC pins of
// all lanes together (VAR_LOAD mode) and observes the q1/q2 outputs.
// PARAMETERS
// WIDTH        1       lanes observed (all share one tap value)
// TAP_WIDTH    9       delay count width
// TAP_MAX      511     last tap swept
// DEFAULT_TAP  9'h19   tap loaded when calibration fails
// MIN_EYE      8       minimum passing-run length accepted
// VTC_WAIT     16      cycles waited after each EN_VTC change
// SETTLE_CYC   8       cycles ignored after each LOAD
// CHECK_CYC    64      cycles compared per tap
// EXP_Q1       {WIDTH{1'b1}}  expected q1 during training
// EXP_Q2       {WIDTH{1'b0}}  expected q2 during training
// PORTS
// clk           in   1          capture clock (same as iddr clk)
// rst           in   1          synchronous, active-high reset
// start         in   1          pulse: begin calibration
// q1            in   WIDTH      iddr rising-edge output
// q2            in   WIDTH      iddr falling-edge output
// dly_cntvalue  out  TAP_WIDTH  IDELAYE3 CNTVALUEIN
// dly_load      out  1          IDELAYE3 LOAD (1-cycle pulse)
// dly_en_vtc    out  1          IDELAYE3 EN_VTC
// busy          out  1          calibration in progress
// done          out  1          calibration finished (held until next start)
// error         out  1          best run < MIN_EYE; DEFAULT_TAP in use
// tap_out       out  TAP_WIDTH  tap finally loaded
// eye_start     out  TAP_WIDTH  first tap of best run
// eye_len       out  TAP_WIDTH+1 length of best run (0..TAP_MAX+1)
// BEHAVIOUR
// - Reset: IDLE; dly_en_vtc=1, dly_load=0, dly_cntvalue=DEFAULT_TAP, busy=done=error=0,
//   tap_out=DEFAULT_TAP, eye_start=0, eye_len=0. Reset mid-sweep aborts immediately.
// - FSM: IDLE->VTC_OFF->LOAD->SETTLE->CHECK->EVAL->(LOAD|FIN_LOAD)->FIN_SETTLE->VTC_ON->DONE.
// - IDLE/DONE: start=1 -> VTC_OFF next cycle; busy=1, done=0, error=0, tap=0, run regs cleared.
//   start while busy is ignored.
// - VTC_OFF: dly_en_vtc=0, stay VTC_WAIT cycles. EN_VTC stays 0 until VTC_ON.
// - LOAD: dly_cntvalue=tap, dly_load=1 for exactly this cycle.
// - SETTLE: SETTLE_CYC cycles, samples ignored.
// - CHECK: CHECK_CYC cycles; tap fails if any cycle has q1!=EXP_Q1 or q2!=EXP_Q2 (any lane).
// - EVAL (1 cycle): pass -> if cur_len==0 cur_start=tap; cur_len++.
//   fail or (pass and tap==TAP_MAX) -> close run: if cur_len>best_len (strict; lowest
//   run wins ties) best<=cur; then cur_len=0. tap==TAP_MAX -> FIN_LOAD, else tap++ -> LOAD.
//   A run still open at TAP_MAX must be included in the comparison the same cycle.
// - FIN_LOAD: best_len>=MIN_EYE -> load best_start+((best_len-1)>>1), error=0;
//   else load DEFAULT_TAP, error=1. dly_load 1-cycle pulse; tap_out/eye_start/eye_len update.
// - FIN_SETTLE: SETTLE_CYC cycles. VTC_ON: dly_en_vtc=1, wait VTC_WAIT cycles.
// - DONE: busy=0, done=1. Per tap cost: 1+SETTLE_CYC+CHECK_CYC+1 cycles.
// - Arithmetic: tap counter TAP_WIDTH bits, never wraps (sweep stops at TAP_MAX);
//   lengths TAP_WIDTH+1 bits.
// TESTING
// Bench models IDELAY: after each dly_load, q1/q2 = EXP values iff loaded tap in window set.
// T1 window 100..180 -> eye_start=100, eye_len=81, tap_out=140, error=0, final load 140.
// T2 windows 20..29 and 300..339 -> eye_start=300, eye_len=40, tap_out=319.
// T3 equal windows 10..19, 50..59 -> lower wins: eye_start=10, tap_out=14.
// T4 window 480..511 (open at TAP_MAX) -> eye_len=32, tap_out=495, error=0.
// T5 no passing tap -> eye_len=0, error=1, tap_out=0x19, done=1, dly_en_vtc=1.
// T6 rst during CHECK -> next cycle busy=0, dly_en_vtc=1, dly_load=0; restart gives T1
//    result; one-cycle glitch at tap 140 in CHECK splits run -> 100..139 best, tap_out=119.

Source files
------------

// File: rtl/idelay_cal_if.sv
// Bundle between the tap calibration controller and the IDELAYE3/IDDR capture path.
// The slave side is the controller; the master side drives start and the captured q1/q2.
interface idelay_cal_if #(
  parameter int WIDTH     = 1,
  parameter int TAP_WIDTH = 9
);
  logic                 start;
  logic [WIDTH-1:0]     q1;
  logic [WIDTH-1:0]     q2;
  logic [TAP_WIDTH-1:0] dly_cntvalue;
  logic                 dly_load;
  logic                 dly_en_vtc;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [TAP_WIDTH-1:0] tap_out;
  logic [TAP_WIDTH-1:0] eye_start;
  logic [TAP_WIDTH:0]   eye_len;

  modport master (
    output start, q1, q2,
    input  dly_cntvalue, dly_load, dly_en_vtc, busy, done, error,
           tap_out, eye_start, eye_len
  );

  modport slave (
    input  start, q1, q2,
    output dly_cntvalue, dly_load, dly_en_vtc, busy, done, error,
           tap_out, eye_start, eye_len
  );
endinterface

// File: rtl/idelay_cal_ctrl.sv
// Sweeps the shared IDELAYE3 tap over 0..TAP_MAX against a fixed training pattern,
// tracks the longest contiguous passing run and loads its centre (or DEFAULT_TAP).
module idelay_cal_ctrl #(
  parameter int                   WIDTH       = 1,
  parameter int                   TAP_WIDTH   = 9,
  parameter int                   TAP_MAX     = 511,
  parameter logic [TAP_WIDTH-1:0] DEFAULT_TAP = 9'h19,
  parameter int                   MIN_EYE     = 8,
  parameter int                   VTC_WAIT    = 16,
  parameter int                   SETTLE_CYC  = 8,
  parameter int                   CHECK_CYC   = 64,
  parameter logic [WIDTH-1:0]     EXP_Q1      = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]     EXP_Q2      = {WIDTH{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  idelay_cal_if.slave   bus
);

  localparam int LW      = TAP_WIDTH + 1;
  localparam int CNT_MAX = (VTC_WAIT > SETTLE_CYC)
                         ? ((VTC_WAIT > CHECK_CYC) ? VTC_WAIT : CHECK_CYC)
                         : ((SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]     VTC_LAST    = CNT_W'(VTC_WAIT - 1);
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]     CHECK_LAST  = CNT_W'(CHECK_CYC - 1);
  localparam logic [TAP_WIDTH-1:0] TAP_LAST    = TAP_WIDTH'(TAP_MAX);
  localparam logic [LW-1:0]        MIN_LEN     = LW'(MIN_EYE);

  typedef enum logic [3:0] {
    S_IDLE,
    S_VTC_OFF,
    S_LOAD,
    S_SETTLE,
    S_CHECK,
    S_EVAL,
    S_FIN_LOAD,
    S_FIN_SETTLE,
    S_VTC_ON,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [TAP_WIDTH-1:0] tap_q;
  logic                 fail_q;
  logic [TAP_WIDTH-1:0] cur_start_q;
  logic [LW-1:0]        cur_len_q;
  logic [TAP_WIDTH-1:0] best_start_q;
  logic [LW-1:0]        best_len_q;

  logic [TAP_WIDTH-1:0] dly_cntvalue_q;
  logic                 dly_load_q;
  logic                 dly_en_vtc_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;
  logic [TAP_WIDTH-1:0] tap_out_q;
  logic [TAP_WIDTH-1:0] eye_start_q;
  logic [LW-1:0]        eye_len_q;

  // Run bookkeeping as it stands at the end of the EVAL cycle.
  logic                 mismatch;
  logic                 pass;
  logic                 at_max;
  logic                 close_run;
  logic                 take_best;
  logic                 eye_ok;
  logic [LW-1:0]        run_len_d;
  logic [TAP_WIDTH-1:0] run_start_d;
  logic [LW-1:0]        best_len_d;
  logic [TAP_WIDTH-1:0] best_start_d;
  logic [LW-1:0]        half_d;
  logic [TAP_WIDTH-1:0] final_tap_d;
  logic [TAP_WIDTH-1:0] tap_inc_d;

  always_comb begin
    mismatch     = (bus.q1 != EXP_Q1) || (bus.q2 != EXP_Q2);
    pass         = !fail_q;
    at_max       = (tap_q == TAP_LAST);
    run_len_d    = pass ? (cur_len_q + LW'(1)) : cur_len_q;
    run_start_d  = (pass && (cur_len_q == '0)) ? tap_q : cur_start_q;
    // A run still open at the last tap is closed and compared in the same cycle.
    close_run    = !pass || at_max;
    take_best    = close_run && (run_len_d > best_len_q);
    best_len_d   = take_best ? run_len_d : best_len_q;
    best_start_d = take_best ? run_start_d : best_start_q;
    eye_ok       = (best_len_d >= MIN_LEN);
    half_d       = (best_len_d - LW'(1)) >> 1;
    final_tap_d  = eye_ok ? (best_start_d + half_d[TAP_WIDTH-1:0]) : DEFAULT_TAP;
    tap_inc_d    = tap_q + TAP_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      tap_q          <= '0;
      fail_q         <= 1'b0;
      cur_start_q    <= '0;
      cur_len_q      <= '0;
      best_start_q   <= '0;
      best_len_q     <= '0;
      dly_cntvalue_q <= DEFAULT_TAP;
      dly_load_q     <= 1'b0;
      dly_en_vtc_q   <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      tap_out_q      <= DEFAULT_TAP;
      eye_start_q    <= '0;
      eye_len_q      <= '0;
    end else begin
      dly_load_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q      <= S_VTC_OFF;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            tap_q        <= '0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            dly_en_vtc_q <= 1'b0;
          end
        end
        S_VTC_OFF: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == VTC_LAST) begin
            state_q        <= S_LOAD;
            dly_cntvalue_q <= tap_q;
            dly_load_q     <= 1'b1;
          end
        end
        S_LOAD: begin
          state_q <= S_SETTLE;
          cnt_q   <= '0;
        end
        S_SETTLE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == SETTLE_LAST) begin
            state_q <= S_CHECK;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
          end
        end
        S_CHECK: begin
          cnt_q  <= cnt_q + CNT_W'(1);
          fail_q <= fail_q | mismatch;
          if (cnt_q == CHECK_LAST) begin
            state_q <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (close_run) begin
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            cur_len_q    <= '0;
          end else begin
            cur_len_q    <= run_len_d;
            cur_start_q  <= run_start_d;
          end
          dly_load_q <= 1'b1;
          if (at_max) begin
            state_q        <= S_FIN_LOAD;
            dly_cntvalue_q <= final_tap_d;
            error_q        <= !eye_ok;
            tap_out_q      <= final_tap_d;
            eye_start_q    <= best_start_d;
            eye_len_q      <= best_len_d;
          end else begin
            state_q        <= S_LOAD;
            tap_q          <= tap_inc_d;
            dly_cntvalue_q <= tap_inc_d;
          end
        end
        S_FIN_LOAD: begin
          state_q <= S_FIN_SETTLE;
          cnt_q   <= '0;
        end
        S_FIN_SETTLE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == SETTLE_LAST) begin
            state_q      <= S_VTC_ON;
            cnt_q        <= '0;
            dly_en_vtc_q <= 1'b1;
          end
        end
        S_VTC_ON: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == VTC_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.dly_cntvalue = dly_cntvalue_q;
  assign bus.dly_load     = dly_load_q;
  assign bus.dly_en_vtc   = dly_en_vtc_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.tap_out      = tap_out_q;
  assign bus.eye_start    = eye_start_q;
  assign bus.eye_len      = eye_len_q;

endmodule

// File: tb/tb_idelay_cal_ctrl.sv
// Directed calibration runs against a behavioural IDELAY whose pass windows are set per
// test; expected results are queued at start and popped when done rises.
module tb_idelay_cal_ctrl;
  localparam int WIDTH      = 1;
  localparam int TAP_WIDTH  = 9;
  localparam int SETTLE_CYC = 2;
  localparam int CHECK_CYC  = 4;
  localparam int VTC_WAIT   = 4;
  localparam int BUDGET     = 8000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  idelay_cal_if #(.WIDTH(WIDTH), .TAP_WIDTH(TAP_WIDTH)) bus ();

  idelay_cal_ctrl #(
    .WIDTH(WIDTH), .TAP_WIDTH(TAP_WIDTH), .TAP_MAX(511), .DEFAULT_TAP(9'h19),
    .MIN_EYE(8), .VTC_WAIT(VTC_WAIT), .SETTLE_CYC(SETTLE_CYC), .CHECK_CYC(CHECK_CYC),
    .EXP_Q1(1'b1), .EXP_Q2(1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int tap;
    int estart;
    int elen;
    int err;
  } exp_t;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Behavioural IDELAY: the loaded tap decides whether the pattern is captured cleanly.
  int  lo0 = 1, hi0 = 0, lo1 = 1, hi1 = 0;
  bit  glitch_en = 1'b0;
  int  loaded_tap = 0;
  int  since = 0;
  int  load_cnt = 0;
  int  load_vtc_off = 0;
  int  last_load = -1;
  logic good;

  always @(posedge clk) begin
    if (bus.start) begin
      load_cnt     <= 0;
      load_vtc_off <= 0;
    end else if (bus.dly_load === 1'b1) begin
      load_cnt     <= load_cnt + 1;
      load_vtc_off <= load_vtc_off + (bus.dly_en_vtc === 1'b0 ? 1 : 0);
    end
    if (bus.dly_load === 1'b1) begin
      loaded_tap <= int'(bus.dly_cntvalue);
      last_load  <= int'(bus.dly_cntvalue);
      since      <= 0;
    end else begin
      since <= since + 1;
    end
  end

  always_comb begin
    good = ((loaded_tap >= lo0) && (loaded_tap <= hi0)) ||
           ((loaded_tap >= lo1) && (loaded_tap <= hi1));
    if (glitch_en && (loaded_tap == 140) && (since == 3)) good = 1'b0;
  end
  assign bus.q1 = good ? 1'b1 : 1'b0;
  assign bus.q2 = good ? 1'b0 : 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_win(input int a0, input int b0, input int a1, input int b1);
    lo0 = a0; hi0 = b0; lo1 = a1; hi1 = b1;
  endtask

  task automatic run_cal(input string name, input int tap, input int estart,
                         input int elen, input int err);
    exp_t e;
    exp_t got;
    e.tap = tap; e.estart = estart; e.elen = elen; e.err = err;
    sb.push_back(e);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check({name, "_busy"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i < BUDGET; i++) begin
      if (bus.done === 1'b1) break;
      @(negedge clk);
    end
    check({name, "_done"}, 32'(bus.done), 32'd1);
    got = sb.pop_front();
    check({name, "_tap_out"},   32'(bus.tap_out),      32'(got.tap));
    check({name, "_eye_start"}, 32'(bus.eye_start),    32'(got.estart));
    check({name, "_eye_len"},   32'(bus.eye_len),      32'(got.elen));
    check({name, "_error"},     32'(bus.error),        32'(got.err));
    check({name, "_cntvalue"},  32'(bus.dly_cntvalue), 32'(got.tap));
    check({name, "_last_load"}, 32'(last_load),        32'(got.tap));
    check({name, "_loads"},     32'(load_cnt),         32'd513);
    check({name, "_loads_vtc0"},32'(load_vtc_off),     32'd513);
    check({name, "_en_vtc"},    32'(bus.dly_en_vtc),   32'd1);
    check({name, "_busy_end"},  32'(bus.busy),         32'd0);
    $display("%s: tap_out=%0d eye_start=%0d eye_len=%0d error=%0b", name,
             bus.tap_out, bus.eye_start, bus.eye_len, bus.error);
  endtask

  initial begin
    bit reached;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en_vtc",   32'(bus.dly_en_vtc),   32'd1);
    check("rst_load",     32'(bus.dly_load),     32'd0);
    check("rst_cntvalue", 32'(bus.dly_cntvalue), 32'h19);
    check("rst_busy",     32'(bus.busy),         32'd0);
    check("rst_done",     32'(bus.done),         32'd0);
    check("rst_error",    32'(bus.error),        32'd0);
    check("rst_tap_out",  32'(bus.tap_out),      32'h19);
    check("rst_eye_start",32'(bus.eye_start),    32'd0);
    check("rst_eye_len",  32'(bus.eye_len),      32'd0);
    $display("reset: state checked");
    rst = 1'b0;

    set_win(100, 180, 1, 0);
    run_cal("T1", 140, 100, 81, 0);
    set_win(20, 29, 300, 339);
    run_cal("T2", 319, 300, 40, 0);
    set_win(10, 19, 50, 59);
    run_cal("T3", 14, 10, 10, 0);
    set_win(480, 511, 1, 0);
    run_cal("T4", 495, 480, 32, 0);
    set_win(1, 0, 1, 0);
    run_cal("T5", 25, 0, 0, 1);

    // Abort in the middle of a CHECK window, then recalibrate from scratch.
    set_win(100, 180, 1, 0);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (loaded_tap == 50 && since == 3) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("T6_reach_check", 32'(reached), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("T6_rst_busy",   32'(bus.busy),       32'd0);
    check("T6_rst_en_vtc", 32'(bus.dly_en_vtc), 32'd1);
    check("T6_rst_load",   32'(bus.dly_load),   32'd0);
    check("T6_rst_done",   32'(bus.done),       32'd0);
    $display("T6: reset mid-sweep checked");
    rst = 1'b0;
    @(negedge clk);
    run_cal("T6_restart", 140, 100, 81, 0);
    glitch_en = 1'b1;
    run_cal("T6_glitch", 119, 100, 40, 0);
    glitch_en = 1'b0;

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
